// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package mul_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/mul_div_sign_fix.sv
// Conditional two's-complement negation; i_cin lets a wide value be negated
// one half at a time (low half gets 1, high half gets the low-half borrow).
module mul_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, i_cin}) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (shift-add / restoring).
// Optional MUL_DIV_UNIT_EARLY_OUT_EN: multiply stops once remaining multiplier bits are zero.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state, w_next;
  logic             r_is_div;
  logic             r_neg_pq;
  logic             r_neg_r;
  logic             r_bzero;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mpl;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand decode at start: magnitudes for signed ops.
  logic             w_sgn;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  assign w_sgn   = op_is_signed(bus.op);
  assign w_a_abs = (w_sgn && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_b_abs = (w_sgn && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Multiply step: r_acc is the upper accumulator, r_mpl the multiplier / product low half.
  logic [WIDTH:0]   w_msum;
  logic [WIDTH-1:0] w_mpl_nx;
  assign w_msum   = {1'b0, r_acc} + (r_mpl[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mpl_nx = {w_msum[0], r_mpl[WIDTH-1:1]};

  // Divide step: r_acc is the remainder, r_mpl the dividend / quotient.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  assign w_shift = {r_acc, r_mpl[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});
  assign w_diff  = w_shift[WIDTH-1:0] - r_mcand;

  logic w_last;
  logic [2*WIDTH-1:0] w_prod;
`ifdef MUL_DIV_UNIT_EARLY_OUT_EN
  logic [WIDTH-1:0] w_mask;
  logic [CW-1:0]    w_rem;
  // Unconsumed multiplier bits sit in the low WIDTH-(r_cnt+1) bits after this step.
  assign w_mask = {WIDTH{1'b1}} >> (r_cnt + 1'b1);
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  (!r_is_div && ((w_mpl_nx & w_mask) == '0));
  assign w_rem  = CW'(WIDTH) - r_cnt;
  assign w_prod = {r_acc, r_mpl} >> w_rem;
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_prod = {r_acc, r_mpl};
`endif

  // Result sign correction.
  logic [WIDTH-1:0] w_plo, w_phi, w_q, w_r;

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_plo (
    .i_val(w_prod[WIDTH-1:0]),       .i_neg(r_neg_pq), .i_cin(1'b1),
    .o_val(w_plo)
  );
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_phi (
    .i_val(w_prod[2*WIDTH-1:WIDTH]), .i_neg(r_neg_pq),
    .i_cin(w_prod[WIDTH-1:0] == '0), .o_val(w_phi)
  );
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .i_val(r_mpl), .i_neg(r_neg_pq), .i_cin(1'b1), .o_val(w_q)
  );
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .i_val(r_acc), .i_neg(r_neg_r),  .i_cin(1'b1), .o_val(w_r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_FIX;
      ST_FIX:                 w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_div <= 1'b0;
      r_neg_pq <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_acc    <= '0;
      r_mpl    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (bus.start) begin
            r_is_div <= op_is_div(bus.op);
            r_neg_pq <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_sgn & bus.a[WIDTH-1];
            r_bzero  <= (bus.b == '0);
            r_acc    <= '0;
            r_mcand  <= op_is_div(bus.op) ? w_b_abs : w_a_abs;
            r_mpl    <= op_is_div(bus.op) ? w_a_abs : w_b_abs;
            r_cnt    <= '0;
            r_dbz    <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (!r_is_div) begin
            r_acc <= w_msum[WIDTH:1];
            r_mpl <= w_mpl_nx;
          end else begin
            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_mpl <= {r_mpl[WIDTH-2:0], w_ge};
          end
        end
        ST_FIX: begin
          // With a zero divisor the remainder path already reproduces a.
          r_hi   <= r_is_div ? w_r : w_phi;
          r_lo   <= r_is_div ? (r_bzero ? {WIDTH{1'b1}} : w_q) : w_plo;
          r_done <= 1'b1;
          if (r_is_div && r_bzero) r_dbz <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.dbz  = r_dbz;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// against a plain-arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  mul_div_unit_if #(.WIDTH(W)) bus();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    logic [63:0] p;
    longint      sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    hi  = '0;
    lo  = '0;
    dbz = 1'b0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (op == OP_DIV) begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MUL_DIV_UNIT_EARLY_OUT_EN
    logic [31:0] m;
    if (!op[1]) begin
      m = (op == OP_MULT && b[31]) ? (~b + 32'd1) : b;
      for (int i = 31; i >= 0; i--) if (m[i]) return 2 + i;
      return 2;
    end
`endif
    return W + 1;
  endfunction

  // disturb>0: during RUN cycle `disturb`, pulse start with another op and hi_we.
  // mt: perform an MTHI in the same cycle as start.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int disturb, input bit mt);
    logic [31:0] ehi, elo, old_hi, old_lo;
    logic        edbz;
    int          lat;
    bit          hold_ok;
    model(op, a, b, ehi, elo, edbz);
    @(negedge clk);
    old_hi = mt ? 32'h5A5A_5A5A : bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.hi_we = mt; bus.wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk({tag, "/dbz_clr"}, {63'b0, bus.dbz}, 64'd0);
    lat = 0;
    hold_ok = 1'b1;
    while (!bus.done && lat < 200) begin
      if (!bus.busy || bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
      if (disturb != 0 && lat == disturb) begin
        bus.start = 1'b1; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
        bus.hi_we = 1'b1; bus.wdata = 32'hBAD0_BAD0;
      end
      if (disturb != 0 && lat == disturb + 1) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk({tag, "/latency"}, 64'(lat), 64'(exp_lat(op, b)));
    chk({tag, "/hold"},    {63'b0, hold_ok}, 64'd1);
    chk({tag, "/busy"},    {63'b0, bus.busy}, 64'd0);
    chk({tag, "/hi"},      {32'b0, bus.hi}, {32'b0, ehi});
    chk({tag, "/lo"},      {32'b0, bus.lo}, {32'b0, elo});
    chk({tag, "/dbz"},     {63'b0, bus.dbz}, {63'b0, edbz});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst/busy", {63'b0, bus.busy}, 64'd0);
    chk("rst/done", {63'b0, bus.done}, 64'd0);
    chk("rst/dbz",  {63'b0, bus.dbz},  64'd0);
    chk("rst/hi",   {32'b0, bus.hi},   64'd0);
    chk("rst/lo",   {32'b0, bus.lo},   64'd0);
    rst_n = 1'b1;

    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h0000_AAAA;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    chk("mthi", {32'b0, bus.hi}, 64'h0000_AAAA);
    @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h0000_5555;
    @(posedge clk); #1; bus.lo_we = 1'b0;
    chk("mtlo", {32'b0, bus.lo}, 64'h0000_5555);
    chk("mtlo/hi_kept", {32'b0, bus.hi}, 64'h0000_AAAA);

    do_op("mult_-3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", {63'b0, bus.done}, 64'd0);
    do_op("div_-7/2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op("divu_big/3", OP_DIVU,  32'h8000_0000, 32'd3, 0, 1'b0);
    do_op("divu_dbz",   OP_DIVU,  32'h0000_1234, 32'd0, 0, 1'b0);
    do_op("multu_clr",  OP_MULTU, 32'd6, 32'd9, 0, 1'b0);
    do_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op("div_dbz_neg", OP_DIV,  32'hFFFF_FF00, 32'd0, 0, 1'b0);
    do_op("divu_disturb", OP_DIVU, 32'hDEAD_BEEF, 32'd77, 5, 1'b0);
    do_op("mult_mt",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd7;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("midrst/pre_hi", {32'b0, bus.hi}, 64'h0000_DEAD);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst/busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst/hi",   {32'b0, bus.hi},   64'd0);
    chk("midrst/lo",   {32'b0, bus.lo},   64'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        2:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        3:       rb = 32'h0000_FFFF & $urandom;
        default: rb = $urandom;
      endcase
      do_op("rand", rop, ra, rb, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
